// File: rtl/ch_demux_if.sv
// ch_demux_if: bundles the sample input, frame control and demultiplexed outputs
// of ch_demux so the driver and the demux connect through a single port.
interface ch_demux_if;
  logic        strobe;
  logic [15:0] din;
  logic [2:0]  channels;
  logic        sync;
  logic [15:0] d0;
  logic [15:0] d1;
  logic [15:0] d2;
  logic [15:0] d3;
  logic [15:0] d4;
  logic [15:0] d5;
  logic [15:0] d6;
  logic [15:0] d7;
  logic        frame_valid;
  logic [2:0]  sel;
  logic [15:0] frame_count;

  modport master (
    output strobe, din, channels, sync,
    input  d0, d1, d2, d3, d4, d5, d6, d7, frame_valid, sel, frame_count
  );

  modport slave (
    input  strobe, din, channels, sync,
    output d0, d1, d2, d3, d4, d5, d6, d7, frame_valid, sel, frame_count
  );
endinterface

// File: rtl/ch_demux.sv
// ch_demux: 8-channel, 16-bit serial-to-parallel frame demultiplexer.
// Define CH_DEMUX_SYNC_EN to build in the frame resynchronization input (sync).
module ch_demux (
  input  logic      clk,
  input  logic      reset,
  ch_demux_if.slave bus
);

  logic [2:0]  sel_q, sel_d, effSel;
  logic [15:0] shadow_q [8];
  logic [15:0] shadow_d [8];
  logic [15:0] dout_q [8];
  logic [15:0] dout_d [8];
  logic        frameValid_q, frameValid_d;
  logic [15:0] frameCount_q, frameCount_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q        <= '0;
      frameValid_q <= 1'b0;
      frameCount_q <= '0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        dout_q[i]   <= '0;
      end
    end else begin
      sel_q        <= sel_d;
      frameValid_q <= frameValid_d;
      frameCount_q <= frameCount_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
    end
  end

  // The completing sample goes straight to its output slot, even when channels
  // was lowered mid-frame below the current index.
  always_comb begin
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    frameValid_d = 1'b0;
    frameCount_d = frameCount_q;
    effSel       = sel_q;
`ifdef CH_DEMUX_SYNC_EN
    if (bus.sync) begin
      effSel = '0;
      if (!bus.strobe) sel_d = '0;
    end
`endif
    if (bus.strobe) begin
      if (effSel < bus.channels) begin
        shadow_d[effSel] = bus.din;
        sel_d            = effSel + 3'd1;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (3'(i) == effSel)
            dout_d[i] = bus.din;
          else if (3'(i) <= bus.channels)
            dout_d[i] = shadow_q[i];
          else
            dout_d[i] = '0;
        end
        sel_d        = '0;
        frameValid_d = 1'b1;
        frameCount_d = frameCount_q + 16'd1;
      end
    end
  end

  assign bus.d0          = dout_q[0];
  assign bus.d1          = dout_q[1];
  assign bus.d2          = dout_q[2];
  assign bus.d3          = dout_q[3];
  assign bus.d4          = dout_q[4];
  assign bus.d5          = dout_q[5];
  assign bus.d6          = dout_q[6];
  assign bus.d7          = dout_q[7];
  assign bus.frame_valid = frameValid_q;
  assign bus.sel         = sel_q;
  assign bus.frame_count = frameCount_q;

endmodule

// File: tb/tb_ch_demux.sv
// tb_ch_demux: directed self-checking bench for ch_demux; inputs change and
// outputs are sampled on the falling clock edge.
module tb_ch_demux;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  logic [15:0] exp [8];

  ch_demux_if bus ();

  ch_demux dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and return on the next falling edge.
  task automatic applyStimulus(input logic s, input logic [15:0] d, input logic sy);
    bus.strobe = s;
    bus.din    = d;
    bus.sync   = sy;
    @(negedge clk);
    if (bus.frame_valid) pulses++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkData(input string tag);
    logic [15:0] obs [8];
    obs = '{bus.d0, bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6, bus.d7};
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s_d%0d", tag, i), 32'(obs[i]), 32'(exp[i]));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pulses       = 0;
    reset        = 1'b0;
    bus.strobe   = 1'b0;
    bus.din      = '0;
    bus.channels = '0;
    bus.sync     = 1'b0;
    repeat (2) @(negedge clk);

    exp = '{default: 16'h0};
    checkData("rst");
    checkOutput("rst_sel", 32'(bus.sel), 0);
    checkOutput("rst_fv", 32'(bus.frame_valid), 0);
    checkOutput("rst_fc", 32'(bus.frame_count), 0);
    reset = 1'b1;

    // Two-channel frame
    bus.channels = 3'd1;
    applyStimulus(1'b1, 16'd1, 1'b0);
    checkOutput("c1_sel1", 32'(bus.sel), 1);
    checkOutput("c1_fv_mid", 32'(bus.frame_valid), 0);
    checkOutput("c1_d0_mid", 32'(bus.d0), 0);
    applyStimulus(1'b1, 16'd2, 1'b0);
    exp = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    checkData("c1");
    checkOutput("c1_fv", 32'(bus.frame_valid), 1);
    checkOutput("c1_fc", 32'(bus.frame_count), 1);
    checkOutput("c1_sel0", 32'(bus.sel), 0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("c1_fv_drop", 32'(bus.frame_valid), 0);
    checkOutput("c1_fc_hold", 32'(bus.frame_count), 1);
    checkOutput("c1_d1_hold", 32'(bus.d1), 2);

    // Full eight-channel frame, back-to-back strobes
    bus.channels = 3'd7;
    pulses = 0;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    checkData("c7");
    checkOutput("c7_sel", 32'(bus.sel), 0);
    checkOutput("c7_fc", 32'(bus.frame_count), 2);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("c7_pulses", 32'(pulses), 1);

    // Partial frame discarded by an asynchronous reset
    bus.channels = 3'd3;
    pulses = 0;
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 1'b0);
    checkOutput("r_sel_pre", 32'(bus.sel), 2);
    checkOutput("r_d0_pre", 32'(bus.d0), 1);
    #2 reset = 1'b0;
    #1;
    exp = '{default: 16'h0};
    checkData("r_async");
    checkOutput("r_async_sel", 32'(bus.sel), 0);
    checkOutput("r_async_fc", 32'(bus.frame_count), 0);
    @(negedge clk);
    applyStimulus(1'b1, 16'hDEAD, 1'b0);
    checkOutput("r_nostrobe_sel", 32'(bus.sel), 0);
    checkOutput("r_nostrobe_d0", 32'(bus.d0), 0);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    checkData("r_post");
    checkOutput("r_pulses", 32'(pulses), 1);
    checkOutput("r_fc", 32'(bus.frame_count), 1);

    // Channel count lowered below the current index mid-frame
    bus.channels = 3'd7;
    for (int i = 10; i <= 14; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    checkOutput("lc_sel5", 32'(bus.sel), 5);
    bus.channels = 3'd2;
    applyStimulus(1'b1, 16'h1234, 1'b0);
    exp = '{16'd10, 16'd11, 16'd12, 16'd0, 16'd0, 16'h1234, 16'd0, 16'd0};
    checkData("lc");
    checkOutput("lc_fv", 32'(bus.frame_valid), 1);
    checkOutput("lc_sel", 32'(bus.sel), 0);
    checkOutput("lc_fc", 32'(bus.frame_count), 2);

    // Single-channel frames
    bus.channels = 3'd0;
    applyStimulus(1'b1, 16'h0055, 1'b0);
    checkOutput("c0_d0a", 32'(bus.d0), 32'h55);
    checkOutput("c0_fva", 32'(bus.frame_valid), 1);
    checkOutput("c0_d5a", 32'(bus.d5), 0);
    applyStimulus(1'b1, 16'h0066, 1'b0);
    checkOutput("c0_d0b", 32'(bus.d0), 32'h66);
    checkOutput("c0_fvb", 32'(bus.frame_valid), 1);
    checkOutput("c0_fc", 32'(bus.frame_count), 4);
    applyStimulus(1'b0, 16'h0, 1'b0);

    // Resynchronization request between frames
    bus.channels = 3'd2;
    pulses = 0;
    applyStimulus(1'b1, 16'd5, 1'b0);
    applyStimulus(1'b1, 16'd6, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1);
`ifdef CH_DEMUX_SYNC_EN
    checkOutput("sy_sel", 32'(bus.sel), 0);
`else
    checkOutput("sy_sel", 32'(bus.sel), 2);
`endif
    checkOutput("sy_fv", 32'(bus.frame_valid), 0);
    applyStimulus(1'b1, 16'd7, 1'b0);
    applyStimulus(1'b1, 16'd8, 1'b0);
    applyStimulus(1'b1, 16'd9, 1'b0);
`ifdef CH_DEMUX_SYNC_EN
    exp = '{16'd7, 16'd8, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
`else
    exp = '{16'd5, 16'd6, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
`endif
    checkData("sy");
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("sy_pulses", 32'(pulses), 1);
    checkOutput("sy_fc", 32'(bus.frame_count), 5);

    // Frame counter wrap
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.channels = 3'd0;
    pulses = 0;
    for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    checkOutput("wr_fc", 32'(bus.frame_count), 0);
    checkOutput("wr_d0", 32'(bus.d0), 32'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("wr_pulses", 32'(pulses), 65536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ch_demux.md
CH_DEMUX -- requirements
Module: ch_demux

Interface
REQ-001 SHALL have no parameters; 8 channels and 16-bit sample width are fixed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port strobe  input  1  sample qualifier; each high clk cycle delivers one sample.
REQ-005 SHALL have port din  input  16  serialized sample, channel order 0,1,...,channels.
REQ-006 SHALL have port channels  input  3  highest channel index in use (number of channels minus 1).
REQ-007 SHALL have port sync  input  1  frame resynchronization request (active only under CH_DEMUX_SYNC_EN).
REQ-008 SHALL have ports d0..d7  output  16 each  demultiplexed channel data, registered.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when d0..d7 update.
REQ-010 SHALL have port sel  output  3  index of the channel the next strobed sample is written to.
REQ-011 SHALL have port frame_count  output  16  number of completed frames, modulo 2^16.

Function
REQ-012 SHALL hold a 3-bit channel index (drives sel), eight 16-bit shadow registers, and eight 16-bit output registers.
REQ-013 On a strobe cycle with sel < channels, SHALL write din to shadow[sel] and increment sel by 1.
REQ-014 On a strobe cycle with sel >= channels, SHALL complete the frame: wrap sel to 0 and load the output registers on the same edge.
REQ-015 At frame completion, outputs 0..channels SHALL take shadow values, with output[sel] taking the current din directly; outputs above channels SHALL load 0.
REQ-016 frame_valid SHALL be high for exactly the one cycle following the completing edge, coincident with the new d0..d7 values; latency is 1 clk from the last strobe.
REQ-017 frame_count SHALL increment by 1 on every frame completion and wrap from 0xFFFF to 0x0000.
REQ-018 With strobe low, sel, shadows, outputs and frame_count SHALL hold; frame_valid SHALL be 0.
REQ-019 With channels = 0, every strobe SHALL complete a frame: d0 = din and frame_valid pulses after each strobe.
REQ-020 If channels is reduced mid-frame below the current sel, the next strobe SHALL complete the frame per REQ-014/015.
REQ-021 Back-to-back strobes on consecutive cycles SHALL each be accepted without loss.
REQ-022 Outputs SHALL change only at frame completion and reset; shadow contents SHALL never appear on d0..d7 mid-frame.

Reset
REQ-023 reset low SHALL immediately and asynchronously clear: sel=0, all shadows=0, d0..d7=0, frame_valid=0, frame_count=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid pulse; the first strobe after release SHALL be treated as channel 0.
REQ-025 Reset deassertion SHALL be sampled synchronously; no strobe SHALL be accepted on the clk edge on which reset is low.

Configuration
REQ-026 Macro CH_DEMUX_SYNC_EN SHALL compile the resynchronization logic in or out.
REQ-027 With CH_DEMUX_SYNC_EN defined, sync high without strobe SHALL set sel=0 and discard the partial frame (no frame_valid, outputs and frame_count hold).
REQ-028 With CH_DEMUX_SYNC_EN defined, sync high with strobe SHALL write din as channel 0 and set sel=1; if channels=0, the frame SHALL complete instead.
REQ-029 Without CH_DEMUX_SYNC_EN, the sync port SHALL remain present but be ignored, with no logic synthesized for it.

Verification
REQ-030 channels=1, strobes with din=1 then din=2 -> d0=1, d1=2, d2..d7=0, frame_valid for one cycle after the second strobe, frame_count=1.
REQ-031 channels=7, din=1..8 on 8 consecutive strobe cycles -> d0..d7=1..8, sel returns to 0, a single frame_valid pulse.
REQ-032 channels=3, two strobes (0xAAAA, 0xBBBB), reset pulse, then 4 strobes 1..4 -> no pulse before reset, all outputs 0 after reset, d0..d3=1..4 after the last strobe.
REQ-033 CH_DEMUX_SYNC_EN defined, channels=2, strobes 5,6, sync alone, then strobes 7,8,9 -> d0=7, d1=8, d2=9, exactly one frame_valid pulse.
REQ-034 channels=0, 65536 strobes -> frame_count wraps to 0x0000 and frame_valid pulses 65536 times.
REQ-035 channels=7, sel=5 when channels is changed to 2, next strobe din=0x1234 -> frame completes with d5=0x1234, d3..d4, d6..d7=0, sel=0.
